risc_core_hs: RTL and testbench



---
 rtl/risc_core_hs_if.sv | 27 ++
 rtl/risc_core_hs.sv | 143 ++++++++++++++
 tb/tb_risc_core_hs.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_core_hs_if.sv
// rtl/risc_core_hs_if.sv - ROM fetch and data RAM req/valid(ack) buses for risc_core_hs
interface risc_core_hs_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 6,
  parameter int ADDR_W = 6
);
  logic              rom_req;
  logic [PC_W-1:0]   rom_addr;
  logic [15:0]       rom_data;
  logic              rom_valid;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;

  modport master (
    output rom_req, rom_addr, ram_req, ram_we, ram_addr, ram_wdata,
    input  rom_data, rom_valid, ram_rdata, ram_ack
  );

  modport slave (
    input  rom_req, rom_addr, ram_req, ram_we, ram_addr, ram_wdata,
    output rom_data, rom_valid, ram_rdata, ram_ack
  );
endinterface

// File: rtl/risc_core_hs.sv
// rtl/risc_core_hs.sv - multi-cycle 16-register core with handshaked ROM fetch and RAM load/store
module risc_core_hs #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 6,
  parameter int ADDR_W = 6
) (
  input  logic            clk_main,
  input  logic            reset,
  risc_core_hs_if.master  bus,
  output logic            retire,
  output logic            halted,
  output logic [PC_W-1:0] pc_out
);
  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [16];
  logic              z;
  logic              rom_req_q;
  logic              ram_req_q;
  logic              ram_we_q;
  logic              retire_q;
  logic              halted_q;

  logic [3:0]        op;
  logic [3:0]        dr;
  logic [3:0]        sa;
  logic [3:0]        sb;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] res;
  logic              wr_en;
  logic              z_en;

  assign op   = ir[15:12];
  assign dr   = ir[11:8];
  assign sa   = ir[7:4];
  assign sb   = ir[3:0];
  assign imm8 = ir[7:0];
  assign a    = regs[sa];
  assign b    = regs[sb];

  always_comb begin
    res   = '0;
    wr_en = 1'b1;
    z_en  = 1'b1;
    case (op)
      4'h1:    res = a + b;
      4'h2:    res = a - b;
      4'h3:    res = a & b;
      4'h4:    res = a | b;
      4'h5:    res = a ^ b;
      4'h6:    res = a << 1;
      4'h7:    res = a >> 1;
      4'h8:    res = DATA_W'(imm8);
      4'hD: begin
        res  = a;
        z_en = 1'b0;
      end
      default: begin
        wr_en = 1'b0;
        z_en  = 1'b0;
      end
    endcase
  end

  // Requests are masked by reset so an in-flight access drops in the reset cycle itself
  assign bus.rom_req   = rom_req_q & ~reset;
  assign bus.rom_addr  = pc;
  assign bus.ram_req   = ram_req_q & ~reset;
  assign bus.ram_we    = ram_we_q & ~reset;
  assign bus.ram_addr  = a[ADDR_W-1:0];
  assign bus.ram_wdata = b;
  assign retire        = retire_q & ~reset;
  assign halted        = halted_q & ~reset;
  assign pc_out        = pc;

  always_ff @(posedge clk_main) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= '0;
      ir        <= '0;
      z         <= 1'b0;
      rom_req_q <= 1'b1;
      ram_req_q <= 1'b0;
      ram_we_q  <= 1'b0;
      retire_q  <= 1'b0;
      halted_q  <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      retire_q <= 1'b0;
      case (state)
        FETCH: begin
          if (bus.rom_valid) begin
            ir        <= bus.rom_data;
            pc        <= pc + PC_W'(1);
            rom_req_q <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (op == 4'h9 || op == 4'hA) begin
            ram_req_q <= 1'b1;
            ram_we_q  <= (op == 4'hA);
            state     <= MEM;
          end else if (op == 4'hF) begin
            retire_q <= 1'b1;
            halted_q <= 1'b1;
            state    <= HALT;
          end else begin
            if (wr_en) regs[dr] <= res;
            if (z_en) z <= (res == '0);
            // pc already points past this instruction, so the branch is relative to pc+1
            if (op == 4'hB && z) pc <= pc + PC_W'($signed(imm8));
            if (op == 4'hC) pc <= PC_W'(imm8);
            retire_q  <= 1'b1;
            rom_req_q <= 1'b1;
            state     <= FETCH;
          end
        end
        MEM: begin
          if (bus.ram_ack) begin
            if (!ram_we_q) begin
              regs[dr] <= bus.ram_rdata;
              z        <= (bus.ram_rdata == '0);
            end
            ram_req_q <= 1'b0;
            ram_we_q  <= 1'b0;
            retire_q  <= 1'b1;
            rom_req_q <= 1'b1;
            state     <= FETCH;
          end
        end
        HALT: begin
          halted_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_risc_core_hs.sv
// tb/tb_risc_core_hs.sv - scoreboard bench for risc_core_hs (16-bit and 8-bit data instances)
module tb_risc_core_hs;
  logic clk_main = 1'b0;
  always #5 clk_main = ~clk_main;

  logic       reset = 1'b1;
  logic       reset8 = 1'b1;
  logic       retire, halted, retire8, halted8;
  logic [5:0] pc_out, pc8;

  risc_core_hs_if #(.DATA_W(16), .PC_W(6), .ADDR_W(6)) bus ();
  risc_core_hs_if #(.DATA_W(8),  .PC_W(6), .ADDR_W(6)) bus8 ();

  risc_core_hs #(.DATA_W(16), .PC_W(6), .ADDR_W(6)) dut (
    .clk_main(clk_main), .reset(reset), .bus(bus),
    .retire(retire), .halted(halted), .pc_out(pc_out)
  );

  risc_core_hs #(.DATA_W(8), .PC_W(6), .ADDR_W(6)) dut8 (
    .clk_main(clk_main), .reset(reset8), .bus(bus8),
    .retire(retire8), .halted(halted8), .pc_out(pc8)
  );

  logic [15:0] rom  [64];
  logic [15:0] ram  [64];
  logic [15:0] rom8 [64];
  int   rom_delay = 0;
  int   ram_delay = 0;
  int   rom_cnt;
  int   ram_cnt;
  logic model_ack = 1'b0;
  logic force_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  int retire_cnt = 0;
  logic [31:0] fetch_q[$];
  logic [31:0] st_q[$];
  logic [31:0] ld_q[$];
  logic [31:0] f8_q[$];
  logic [31:0] st8_q[$];

  assign bus.ram_ack = model_ack | force_ack;

  // zero-wait memories for the 8-bit instance
  assign bus8.rom_valid = bus8.rom_req;
  assign bus8.rom_data  = rom8[bus8.rom_addr];
  assign bus8.ram_ack   = bus8.ram_req;
  assign bus8.ram_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  initial begin
    bus.rom_valid = 1'b0;
    bus.rom_data  = '0;
    rom_cnt = 0;
    forever begin
      @(negedge clk_main);
      if (!bus.rom_req) begin
        rom_cnt = 0;
        bus.rom_valid = 1'b0;
      end else if (rom_cnt >= rom_delay) begin
        bus.rom_valid = 1'b1;
        bus.rom_data  = rom[bus.rom_addr];
      end else begin
        rom_cnt++;
        bus.rom_valid = 1'b0;
      end
    end
  end

  initial begin
    bus.ram_rdata = '0;
    ram_cnt = 0;
    forever begin
      @(negedge clk_main);
      if (!bus.ram_req) begin
        ram_cnt = 0;
        model_ack = 1'b0;
      end else if (ram_cnt >= ram_delay) begin
        model_ack = 1'b1;
        if (bus.ram_we) ram[bus.ram_addr] = bus.ram_wdata;
        else bus.ram_rdata = ram[bus.ram_addr];
      end else begin
        ram_cnt++;
        model_ack = 1'b0;
      end
    end
  end

  // monitor: pops expected transactions whenever a handshake completes
  initial begin
    forever begin
      @(negedge clk_main);
      #2;
      if (retire) retire_cnt++;
      if (bus.rom_req && bus.rom_valid) begin
        if (fetch_q.size() == 0) chk("fetch_extra", 32'(bus.rom_addr), 32'hFFFF_FFFF);
        else chk("fetch_addr", 32'(bus.rom_addr), fetch_q.pop_front());
      end
      if (bus.ram_req && bus.ram_ack) begin
        if (bus.ram_we) begin
          if (st_q.size() == 0) chk("store_extra", {10'd0, bus.ram_addr, bus.ram_wdata}, 32'hFFFF_FFFF);
          else chk("store", {10'd0, bus.ram_addr, bus.ram_wdata}, st_q.pop_front());
        end else begin
          if (ld_q.size() == 0) chk("load_extra", 32'(bus.ram_addr), 32'hFFFF_FFFF);
          else chk("load_addr", 32'(bus.ram_addr), ld_q.pop_front());
        end
      end
      if (bus8.rom_req && bus8.rom_valid) begin
        if (f8_q.size() == 0) chk("fetch8_extra", 32'(bus8.rom_addr), 32'hFFFF_FFFF);
        else chk("fetch8_addr", 32'(bus8.rom_addr), f8_q.pop_front());
      end
      if (bus8.ram_req && bus8.ram_ack && bus8.ram_we) begin
        if (st8_q.size() == 0) chk("store8_extra", {18'd0, bus8.ram_addr, bus8.ram_wdata}, 32'hFFFF_FFFF);
        else chk("store8", {18'd0, bus8.ram_addr, bus8.ram_wdata}, st8_q.pop_front());
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 16'hF000;
  endtask

  task automatic pulse_reset();
    @(posedge clk_main);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk_main);
    #1 reset = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int n;
    n = 0;
    while (!halted && n < 3000) begin
      @(negedge clk_main);
      #2;
      n++;
    end
    chk(name, 32'(halted), 32'd1);
    repeat (2) @(negedge clk_main);
    #2;
  endtask

  initial begin
    int base;
    int n;
    int req_cycles;
    logic addr_bad;
    logic [15:0] p1 [12];
    logic [15:0] p4 [26];

    for (int i = 0; i < 64; i++) begin
      rom8[i] = 16'hF000;
      ram[i]  = '0;
    end
    clear_rom();

    // reset state
    repeat (2) @(posedge clk_main);
    #1;
    chk("rst_rom_req", 32'(bus.rom_req), 0);
    chk("rst_ram_req", 32'(bus.ram_req), 0);
    chk("rst_ram_we", 32'(bus.ram_we), 0);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pc", 32'(pc_out), 0);

    // zero-wait ALU ops, store, BZ taken then not taken
    p1 = '{16'h8105, 16'h8203, 16'h1312, 16'h8A0A, 16'hA0A3, 16'h2411,
           16'hB002, 16'h8577, 16'hF000, 16'h8601, 16'hB002, 16'hF000};
    for (int i = 0; i < 12; i++) rom[i] = p1[i];
    foreach (p1[i]) if (i != 7 && i != 8) fetch_q.push_back(32'(i));
    st_q.push_back(32'h000A_0008);
    base = retire_cnt;
    pulse_reset();
    repeat (6) @(posedge clk_main);
    #1 chk("pc_after_6_cycles", 32'(pc_out), 3);
    wait_halt("t1_halt");
    chk("t1_retires", 32'(retire_cnt - base), 10);
    chk("t1_fetch_q_empty", 32'(fetch_q.size()), 0);
    chk("t1_store_q_empty", 32'(st_q.size()), 0);

    // fetch with rom_valid delayed 3 cycles
    clear_rom();
    rom[0] = 16'h8142;
    rom_delay = 3;
    fetch_q.push_back(0);
    fetch_q.push_back(1);
    pulse_reset();
    req_cycles = 0;
    addr_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_main);
      #2;
      if (bus.rom_req) begin
        req_cycles++;
        if (bus.rom_addr != 6'd0 || pc_out != 6'd0) addr_bad = 1'b1;
      end
      if (bus.rom_valid) break;
    end
    chk("slow_rom_req_cycles", 32'(req_cycles), 4);
    chk("slow_rom_addr_stable", 32'(addr_bad), 0);
    @(posedge clk_main);
    #1 chk("slow_rom_pc_once", 32'(pc_out), 1);
    wait_halt("t2_halt");
    rom_delay = 0;

    // store/load with ack after 2 cycles, logic/shift/move ops
    clear_rom();
    p4 = '{16'h810A, 16'h82BE, 16'h6220, 16'h6220, 16'h6220, 16'h6220, 16'h6220,
           16'h6220, 16'h6220, 16'h6220, 16'h84EF, 16'h4224, 16'hA012, 16'h9610,
           16'hB002, 16'h8B0B, 16'hA0B6, 16'h7760, 16'h5876, 16'h3976, 16'h8C0C,
           16'hA0C8, 16'hDD90, 16'hA0CD, 16'hE000, 16'hF000};
    for (int i = 0; i < 26; i++) begin
      rom[i] = p4[i];
      fetch_q.push_back(32'(i));
    end
    st_q.push_back(32'h000A_BEEF);
    st_q.push_back(32'h000B_BEEF);
    st_q.push_back(32'h000C_E198);
    st_q.push_back(32'h000C_1E67);
    ld_q.push_back(32'd10);
    ram_delay = 2;
    pulse_reset();
    wait_halt("t3_halt");
    chk("t3_fetch_q_empty", 32'(fetch_q.size()), 0);
    chk("t3_store_q_empty", 32'(st_q.size()), 0);
    chk("t3_load_q_empty", 32'(ld_q.size()), 0);
    chk("t3_ram10", 32'(ram[10]), 32'h0000_BEEF);
    ram_delay = 0;

    // DATA_W=8 wrap of ADD and of pc after JMP 0x3F
    rom8[0] = 16'hB00A; rom8[1] = 16'h81FF; rom8[2] = 16'h8201; rom8[3] = 16'h1312;
    rom8[4] = 16'hB002; rom8[7] = 16'h840A; rom8[8] = 16'hA043; rom8[9] = 16'hC03F;
    rom8[63] = 16'h2555;
    f8_q = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd7, 32'd8, 32'd9, 32'd63, 32'd0, 32'd11};
    st8_q.push_back(32'h0000_0A00);
    @(posedge clk_main);
    #1 reset8 = 1'b0;
    n = 0;
    while (!halted8 && n < 500) begin
      @(negedge clk_main);
      #2;
      n++;
    end
    chk("t4_halt8", 32'(halted8), 1);
    chk("t4_pc8", 32'(pc8), 12);
    chk("t4_fetch8_q_empty", 32'(f8_q.size()), 0);
    chk("t4_store8_q_empty", 32'(st8_q.size()), 0);

    // reset while waiting for a load ack, then a stray ack during fetch
    clear_rom();
    rom[0] = 16'h810A;
    rom[1] = 16'h9210;
    fetch_q.push_back(0);
    fetch_q.push_back(1);
    ram_delay = 1000;
    pulse_reset();
    n = 0;
    while (!bus.ram_req && n < 50) begin
      @(negedge clk_main);
      #2;
      n++;
    end
    chk("t5_mem_reached", 32'(bus.ram_req), 1);
    @(posedge clk_main);
    #1 reset = 1'b1;
    #1;
    chk("t5_ram_req_drops", 32'(bus.ram_req), 0);
    chk("t5_ram_we_drops", 32'(bus.ram_we), 0);
    chk("t5_rom_req_in_reset", 32'(bus.rom_req), 0);
    rom[0] = 16'h8709;
    rom[1] = 16'hA077;
    rom[2] = 16'hF000;
    fetch_q.push_back(0);
    fetch_q.push_back(1);
    fetch_q.push_back(2);
    st_q.push_back(32'h0009_0009);
    rom_delay = 2;
    ram_delay = 0;
    @(posedge clk_main);
    #1 reset = 1'b0;
    force_ack = 1'b1;
    @(posedge clk_main);
    #1 force_ack = 1'b0;
    chk("t5_late_ack_no_retire", 32'(retire), 0);
    chk("t5_late_ack_pc", 32'(pc_out), 0);
    wait_halt("t5_halt");
    chk("t5_pc_at_halt", 32'(pc_out), 3);
    repeat (5) @(negedge clk_main);
    #2;
    chk("halt_sticky", 32'(halted), 1);
    chk("halt_no_fetch", 32'(bus.rom_req), 0);
    chk("halt_pc_frozen", 32'(pc_out), 3);
    chk("t5_fetch_q_empty", 32'(fetch_q.size()), 0);
    chk("t5_store_q_empty", 32'(st_q.size()), 0);
    @(posedge clk_main);
    #1 reset = 1'b1;
    #1 chk("halt_cleared_by_reset", 32'(halted), 0);
    repeat (2) @(posedge clk_main);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
